// File: rtl/sg_lock_pkg.sv
// Shared definitions for the syncgen lock controller: state encoding and default counter width.
package sg_lock_pkg;

    localparam int V_CNT_W_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_ARM     = 2'd2,
        ST_LOCKED  = 2'd3
    } lock_state_t;

    localparam logic [7:0] RELOCK_MAX = 8'hFF;

endpackage

// File: rtl/sg_lock_ctrl_if.sv
// Control, sync-reference and status bundle between the lock controller and its environment.
interface sg_lock_ctrl_if
    import sg_lock_pkg::*;
#(
    parameter int V_CNT_W = V_CNT_W_DEF
);
    logic               enable;
    logic               v_change;
    logic               HSYNC_ref;
    logic               VSYNC_ref;
    logic [V_CNT_W-1:0] v_total;
    logic               sg_reset_n;
    logic               locked;
    logic [1:0]         state;
    logic [V_CNT_W-1:0] frame_lines;
    logic [7:0]         relock_cnt;

    modport master (
        output enable, v_change, HSYNC_ref, VSYNC_ref, v_total,
        input  sg_reset_n, locked, state, frame_lines, relock_cnt
    );

    modport slave (
        input  enable, v_change, HSYNC_ref, VSYNC_ref, v_total,
        output sg_reset_n, locked, state, frame_lines, relock_cnt
    );
endinterface

// File: rtl/sg_line_meter.sv
// Counts hsync falling edges per vsync period and judges each completed frame against v_total.
// frame_done/good are combinational in the vsync-edge cycle; frame_lines updates one cycle later.
module sg_line_meter
    import sg_lock_pkg::*;
#(
    parameter int V_CNT_W = V_CNT_W_DEF,
    parameter int V_TOL   = 2
) (
    input  logic               PCLK,
    input  logic               reset,
    input  logic               HSYNC_ref,
    input  logic               VSYNC_ref,
    input  logic [V_CNT_W-1:0] v_total,
    output logic               frame_done,
    output logic [V_CNT_W-1:0] frame_lines,
    output logic               line_sat,
    output logic               good
);
    localparam logic [V_CNT_W-1:0] CNT_MAX = '1;
    localparam logic signed [V_CNT_W:0] TOL_S = (V_CNT_W+1)'(V_TOL);

    logic               r_hs_prev;
    logic               r_vs_prev;
    logic [V_CNT_W-1:0] r_line_cnt;
    logic [V_CNT_W-1:0] r_frame_lines;

    logic               w_hs_fall;
    logic               w_vs_fall;
    logic [V_CNT_W-1:0] w_line_inc;
    logic [V_CNT_W-1:0] w_lines_new;
    logic signed [V_CNT_W:0] w_diff;
    logic signed [V_CNT_W:0] w_abs;

    assign w_hs_fall   = r_hs_prev & ~HSYNC_ref;
    assign w_vs_fall   = r_vs_prev & ~VSYNC_ref;
    assign w_line_inc  = (r_line_cnt == CNT_MAX) ? CNT_MAX : r_line_cnt + V_CNT_W'(1);
    // A line whose hsync falls together with vsync still belongs to the closing frame.
    assign w_lines_new = w_hs_fall ? w_line_inc : r_line_cnt;

    assign w_diff = $signed({1'b0, w_lines_new}) - $signed({1'b0, v_total});
    assign w_abs  = w_diff[V_CNT_W] ? -w_diff : w_diff;

    assign frame_done  = w_vs_fall;
    assign good        = (w_abs <= TOL_S);
    assign frame_lines = r_frame_lines;
    assign line_sat    = (r_line_cnt == CNT_MAX);

    always_ff @(posedge PCLK) begin
        if (reset) begin
            r_hs_prev     <= 1'b1;
            r_vs_prev     <= 1'b1;
            r_line_cnt    <= '0;
            r_frame_lines <= '0;
        end else begin
            r_hs_prev <= HSYNC_ref;
            r_vs_prev <= VSYNC_ref;
            if (w_vs_fall) begin
                r_frame_lines <= w_lines_new;
                r_line_cnt    <= '0;
            end else if (w_hs_fall) begin
                r_line_cnt <= w_line_inc;
            end
        end
    end

endmodule

// File: rtl/sg_lock_ctrl.sv
// Qualifies the input timing for STABLE_FRAMES frames, then releases the syncgen reset at a vsync edge.
// sg_reset_n/locked are registered: they follow the state decision by one cycle; drops force IDLE at once.
module sg_lock_ctrl
    import sg_lock_pkg::*;
#(
    parameter int STABLE_FRAMES = 3,
    parameter int V_TOL         = 2,
    parameter int V_CNT_W       = V_CNT_W_DEF
) (
    input  logic           PCLK,
    input  logic           reset,
    sg_lock_ctrl_if.slave  bus
);
    localparam int SC_W = $clog2(STABLE_FRAMES + 1);
    localparam logic [SC_W-1:0] STABLE_TGT = SC_W'(STABLE_FRAMES);

    lock_state_t     r_state;
    logic [SC_W-1:0] r_stable_cnt;
    logic            r_first_seen;
    logic [7:0]      r_relock_cnt;
    logic            r_sg_reset_n;
    logic            r_locked;

    lock_state_t     w_state_nxt;
    logic [SC_W-1:0] w_stable_nxt;
    logic [SC_W-1:0] w_stable_inc;
    logic            w_first_nxt;
    logic [7:0]      w_relock_nxt;
    logic            w_sg_reset_n_nxt;
    logic            w_locked_nxt;

    logic               w_frame_done;
    logic [V_CNT_W-1:0] w_frame_lines;
    logic               w_line_sat;
    logic               w_good;

    sg_line_meter #(
        .V_CNT_W (V_CNT_W),
        .V_TOL   (V_TOL)
    ) u_meter (
        .PCLK        (PCLK),
        .reset       (reset),
        .HSYNC_ref   (bus.HSYNC_ref),
        .VSYNC_ref   (bus.VSYNC_ref),
        .v_total     (bus.v_total),
        .frame_done  (w_frame_done),
        .frame_lines (w_frame_lines),
        .line_sat    (w_line_sat),
        .good        (w_good)
    );

    assign w_stable_inc = r_stable_cnt + SC_W'(1);

    always_ff @(posedge PCLK) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_stable_cnt <= '0;
            r_first_seen <= 1'b0;
            r_relock_cnt <= '0;
            r_sg_reset_n <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_stable_cnt <= w_stable_nxt;
            r_first_seen <= w_first_nxt;
            r_relock_cnt <= w_relock_nxt;
            r_sg_reset_n <= w_sg_reset_n_nxt;
            r_locked     <= w_locked_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_stable_nxt = r_stable_cnt;
        w_first_nxt  = r_first_seen;
        w_relock_nxt = r_relock_cnt;
        // Disable or mode change overrides everything and is not counted as a lock loss.
        if (!bus.enable || bus.v_change) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt  = ST_QUALIFY;
                    w_stable_nxt = '0;
                    w_first_nxt  = 1'b0;
                end
                ST_QUALIFY: begin
                    if (w_frame_done) begin
                        if (!r_first_seen) begin
                            w_first_nxt = 1'b1;
                        end else if (w_good) begin
                            w_stable_nxt = w_stable_inc;
                            if (w_stable_inc == STABLE_TGT) begin
                                w_state_nxt = ST_ARM;
                            end
                        end else begin
                            w_stable_nxt = '0;
                        end
                    end
                end
                ST_ARM: begin
                    if (w_frame_done) begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if ((w_frame_done && !w_good) || w_line_sat) begin
                        w_state_nxt = ST_IDLE;
                        if (r_relock_cnt != RELOCK_MAX) begin
                            w_relock_nxt = r_relock_cnt + 8'd1;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_sg_reset_n_nxt = (w_state_nxt == ST_LOCKED);
        w_locked_nxt     = (w_state_nxt == ST_LOCKED);
    end

    assign bus.sg_reset_n  = r_sg_reset_n;
    assign bus.locked      = r_locked;
    assign bus.state       = r_state;
    assign bus.frame_lines = w_frame_lines;
    assign bus.relock_cnt  = r_relock_cnt;

endmodule

// File: tb/tb_sg_lock_ctrl.sv
// Randomized frame stimulus for sg_lock_ctrl checked against a cycle-level reference model.
module tb_sg_lock_ctrl;
    import sg_lock_pkg::*;

    localparam int W      = 11;
    localparam int MAXL   = 2047;
    localparam int TOL    = 2;
    localparam int STABLE = 3;

    logic PCLK = 1'b0;
    logic reset;

    sg_lock_ctrl_if #(.V_CNT_W(W)) bus ();

    sg_lock_ctrl #(
        .STABLE_FRAMES (STABLE),
        .V_TOL         (TOL),
        .V_CNT_W       (W)
    ) dut (
        .PCLK  (PCLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_err = 0;

    // reference model: states numbered IDLE=0, QUALIFY=1, ARM=2, LOCKED=3
    int m_state, m_lines, m_fl, m_stable, m_relock;
    bit m_first, m_sgrn;
    bit b_hs_prev = 1'b1;
    bit b_vs_prev = 1'b1;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit hs_f, input bit vs_f,
                              input bit en, input bit vc, input int vt);
        int nxt;
        int fl_new;
        bit good;
        if (rst) begin
            m_state = 0; m_lines = 0; m_fl = 0; m_stable = 0;
            m_relock = 0; m_first = 0; m_sgrn = 0;
            return;
        end
        fl_new = m_lines + (hs_f ? 1 : 0);
        if (fl_new > MAXL) fl_new = MAXL;
        good = ((fl_new - vt) <= TOL) && ((vt - fl_new) <= TOL);
        nxt = m_state;
        if (!en || vc) begin
            nxt = 0;
        end else if (m_state == 0) begin
            nxt = 1; m_stable = 0; m_first = 0;
        end else if (m_state == 1 && vs_f) begin
            if (!m_first) m_first = 1;
            else if (good) begin
                m_stable++;
                if (m_stable == STABLE) nxt = 2;
            end else m_stable = 0;
        end else if (m_state == 2 && vs_f) begin
            nxt = 3;
        end else if (m_state == 3 && ((vs_f && !good) || m_lines == MAXL)) begin
            nxt = 0;
            if (m_relock < 255) m_relock++;
        end
        if (vs_f) begin
            m_fl = fl_new;
            m_lines = 0;
        end else if (hs_f && m_lines < MAXL) begin
            m_lines++;
        end
        m_state = nxt;
        m_sgrn  = (nxt == 3);
    endtask

    task automatic check_all();
        chk("state", int'(bus.state), m_state);
        chk("sg_reset_n", int'(bus.sg_reset_n), int'(m_sgrn));
        chk("locked", int'(bus.locked), int'(m_sgrn));
        chk("frame_lines", int'(bus.frame_lines), m_fl);
        chk("relock_cnt", int'(bus.relock_cnt), m_relock);
    endtask

    task automatic tick();
        bit hs_f, vs_f;
        int prev_state;
        hs_f = b_hs_prev && !bus.HSYNC_ref;
        vs_f = b_vs_prev && !bus.VSYNC_ref;
        prev_state = m_state;
        @(posedge PCLK);
        #1;
        model_step(reset, hs_f, vs_f, bus.enable, bus.v_change, int'(bus.v_total));
        b_hs_prev = reset ? 1'b1 : bus.HSYNC_ref;
        b_vs_prev = reset ? 1'b1 : bus.VSYNC_ref;
        if (vs_f || reset || m_state != prev_state) check_all();
    endtask

    task automatic line();
        bus.HSYNC_ref = 1'b0; tick();
        bus.HSYNC_ref = 1'b1; tick();
    endtask

    // n lines then a vsync edge; with coin the last hsync edge coincides with the vsync edge
    task automatic frame(input int n, input bit coin);
        for (int i = 0; i < n; i++) begin
            if (coin && i == n - 1) begin
                bus.HSYNC_ref = 1'b0; bus.VSYNC_ref = 1'b0; tick();
                bus.HSYNC_ref = 1'b1; bus.VSYNC_ref = 1'b1; tick();
            end else begin
                line();
            end
        end
        if (!coin || n == 0) begin
            bus.VSYNC_ref = 1'b0; tick();
            bus.VSYNC_ref = 1'b1;
        end
    endtask

    task automatic vc_pulse();
        bus.v_change = 1'b1; tick();
        bus.v_change = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rel0;
        reset = 1'b1;
        bus.enable = 1'b0; bus.v_change = 1'b0;
        bus.HSYNC_ref = 1'b1; bus.VSYNC_ref = 1'b1;
        bus.v_total = 11'd262;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_state", int'(bus.state), 0);
        chk("rst_sg_reset_n", int'(bus.sg_reset_n), 0);
        chk("rst_frame_lines", int'(bus.frame_lines), 0);
        chk("rst_relock", int'(bus.relock_cnt), 0);

        // basic lock sequence
        bus.enable = 1'b1; tick();
        chk("enter_qualify", int'(bus.state), 1);
        for (int k = 1; k <= 5; k++) begin
            frame(262, (k == 4) ? 1'b1 : ((k == 5) ? 1'b0 : 1'($urandom % 2)));
            if (k == 4) begin
                chk("arm_after_4th", int'(bus.state), 2);
                chk("coincident_lines", int'(bus.frame_lines), 262);
                chk("arm_sg_reset_n", int'(bus.sg_reset_n), 0);
            end
        end
        chk("locked_sg_reset_n", int'(bus.sg_reset_n), 1);
        chk("locked_flag", int'(bus.locked), 1);

        // mode change pulse: no lock-loss count
        vc_pulse();
        chk("vchg_idle", int'(bus.state), 0);
        chk("vchg_relock", int'(bus.relock_cnt), 0);
        tick();

        // tolerance edge in QUALIFY: 265 resets the count, 264 is good
        frame(262, 0); frame(262, 0); frame(262, 0); frame(265, 0);
        chk("tol_265_reset", int'(bus.state), 1);
        frame(262, 0); frame(262, 0); frame(264, 0);
        chk("tol_264_good", int'(bus.state), 2);
        frame(262, 0);
        chk("relock_tol", int'(bus.state), 3);

        // bad frame in LOCKED
        frame(300, 0);
        chk("bad_idle", int'(bus.state), 0);
        chk("bad_sg_reset_n", int'(bus.sg_reset_n), 0);
        chk("bad_relock", int'(bus.relock_cnt), 1);
        for (int k = 0; k < 5; k++) frame(262, 1'($urandom % 2));
        chk("relock_5", int'(bus.locked), 1);

        // line counter saturation in LOCKED
        for (int k = 0; k < 2048; k++) line();
        chk("sat_unlocked", int'(bus.locked), 0);
        chk("sat_relock", int'(bus.relock_cnt), 2);
        frame(0, 0);
        chk("sat_frame_lines", int'(bus.frame_lines), MAXL);

        // reset while locked
        for (int k = 0; k < 5; k++) frame(262, 1'($urandom % 2));
        for (int k = 0; k < 40; k++) line();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midrst_state", int'(bus.state), 0);
        chk("midrst_relock", int'(bus.relock_cnt), 0);
        tick();

        // relock counter saturation with short frames
        bus.v_total = 11'd8;
        for (int it = 0; it < 260; it++) begin
            for (int k = 0; k < 5; k++) frame($urandom_range(6, 10), 1'($urandom % 2));
            rel0 = m_relock;
            frame($urandom_range(14, 30), 1'b0);
            if (it < 3) chk("loss_count", int'(bus.relock_cnt), rel0 + 1);
            tick();
            if ($urandom % 8 == 0) vc_pulse();
        end
        chk("relock_sat", int'(bus.relock_cnt), 255);

        // random mixture
        for (int it = 0; it < 120; it++) begin
            if ($urandom % 16 == 0) bus.v_total = 11'($urandom_range(8, 40));
            case ($urandom % 10)
                0: vc_pulse();
                1: begin
                    bus.enable = 1'b0;
                    repeat ($urandom_range(1, 3)) tick();
                    bus.enable = 1'b1;
                end
                default: ;
            endcase
            frame(int'(bus.v_total) + $urandom_range(0, 8) - 4, 1'($urandom % 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
